phx_ram_arbiter: RTL

- Shares the Phoenix single-port work RAM between the game CPU and the hiscore save/restore engine.
- Before granting the hiscore engine, pauses the CPU and waits for its bus to settle.
- Services byte read/write requests, then releases the CPU after an idle timeout.
- Sits between the hiscore engine, the user pause toggle and the phoenix core RAM port, in the clk_sys domain.

---
 rtl/phx_ram_arbiter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/phx_ram_arbiter.sv
// ---------------------------------------------------------------------------
// phx_ram_arbiter
//
// Shares the Phoenix single-port work RAM between the game CPU and the
// hiscore save/restore engine (clk_sys domain).
//
// How the RAM changes hands:
//   IDLE    : CPU owns the RAM.
//   DRAIN   : the CPU is paused, but the RAM stays muxed to the CPU with its
//             writes suppressed. We then wait SETTLE cpu_ce strobes so any
//             bus cycle already in flight can finish.
//   GRANT   : the hiscore engine owns the RAM and requests are accepted.
//   ACCESS  : a single byte read or write is performed, ending with a
//             one-cycle hs_ack.
//   RELEASE : one cycle that hands the RAM back to the CPU with writes
//             suppressed, before returning to IDLE.
//
// Ports:
//   clk         system clock (clk_sys)
//   reset_n     asynchronous active-low reset
//   cpu_ce      CPU bus-cycle strobe, one clk wide
//   user_pause  user pause level (already toggled upstream)
//   cpu_addr    CPU RAM address             cpu_wdata  CPU write data
//   cpu_we      CPU write enable
//   hs_req      hiscore request, held until hs_ack
//   hs_we       hiscore write(1)/read(0), sampled with hs_req
//   hs_addr     hiscore address             hs_wdata   hiscore write data
//   hs_ack      one-cycle completion pulse
//   hs_rdata    read data, valid in the hs_ack cycle, held between acks
//   ram_addr    RAM address                 ram_wdata  RAM write data
//   ram_we      RAM write strobe            ram_rdata  RAM read data
//   cpu_pause   pause to the phoenix core
//   hs_busy     high while the hiscore engine owns the RAM
//
// Optional feature (macro ARB_PAUSE_DIM_EN):
//   Adds parameter DIM_CYCLES and output dim. A 32-bit timer runs while
//   user_pause is high and clears when it is low. dim goes high once the
//   timer reaches DIM_CYCLES, and the timer then holds at that value.
//   Pauses caused by the hiscore engine never start the timer.
// ---------------------------------------------------------------------------
module phx_ram_arbiter #(
    parameter int AW           = 16,
    parameter int SETTLE       = 4,
    parameter int RD_LAT       = 1,
    parameter int IDLE_TIMEOUT = 64
`ifdef ARB_PAUSE_DIM_EN
    ,
    parameter logic [31:0] DIM_CYCLES = 32'h68E7780
`endif
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_ce,
    input  logic          user_pause,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    input  logic          cpu_we,
    input  logic          hs_req,
    input  logic          hs_we,
    input  logic [AW-1:0] hs_addr,
    input  logic [7:0]    hs_wdata,
    output logic          hs_ack,
    output logic [7:0]    hs_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    output logic          ram_we,
    input  logic [7:0]    ram_rdata,
    output logic          cpu_pause,
    output logic          hs_busy
`ifdef ARB_PAUSE_DIM_EN
    ,
    output logic          dim
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_GRANT,
        ST_ACCESS,
        ST_RELEASE
    } state_t;

    // Terminal values of the counters, sized to match the counter widths.
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
    localparam logic [1:0] LAT_M1    = 2'(RD_LAT - 1);
    localparam logic [7:0] IDLE_M1   = 8'(IDLE_TIMEOUT - 1);

    state_t     state_reg;
    logic [3:0] settle_cnt_reg;
    logic [7:0] idle_cnt_reg;
    logic [1:0] lat_cnt_reg;
    logic       we_lat_reg;
    logic       hs_ack_reg;
    logic [7:0] hs_rdata_reg;

    // -----------------------------------------------------------------------
    // Arbitration FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            settle_cnt_reg <= 4'd0;
            idle_cnt_reg   <= 8'd0;
            lat_cnt_reg    <= 2'd0;
            we_lat_reg     <= 1'b0;
            hs_ack_reg     <= 1'b0;
            hs_rdata_reg   <= 8'd0;
        end else begin
            // hs_ack is a single-cycle pulse. It drops unless it is set below.
            hs_ack_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (hs_req) begin
                        state_reg      <= ST_DRAIN;
                        settle_cnt_reg <= 4'd0;
                    end
                end

                // Once entered, DRAIN always runs to GRANT. A withdrawn
                // request simply ends in an idle timeout.
                ST_DRAIN: begin
                    if (cpu_ce) begin
                        if (settle_cnt_reg != 4'hF) begin
                            settle_cnt_reg <= settle_cnt_reg + 4'd1;
                        end
                        if (settle_cnt_reg >= SETTLE_M1) begin
                            state_reg    <= ST_GRANT;
                            idle_cnt_reg <= 8'd0;
                        end
                    end
                end

                ST_GRANT: begin
                    if (hs_req) begin
                        we_lat_reg   <= hs_we;
                        lat_cnt_reg  <= 2'd0;
                        idle_cnt_reg <= 8'd0;
                        state_reg    <= ST_ACCESS;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + 8'd1;
                        if (idle_cnt_reg == IDLE_M1) begin
                            state_reg <= ST_RELEASE;
                        end
                    end
                end

                // ACCESS always ends with a cycle in which hs_ack is visible.
                // GRANT follows that cycle, so a request still held during
                // the ack cycle is not accepted a second time.
                ST_ACCESS: begin
                    if (hs_ack_reg) begin
                        state_reg <= ST_GRANT;
                    end else if (we_lat_reg) begin
                        hs_ack_reg <= 1'b1;
                    end else if (lat_cnt_reg == LAT_M1) begin
                        // hs_addr was already on the RAM during GRANT, so
                        // RD_LAT cycles have elapsed by this point.
                        hs_ack_reg   <= 1'b1;
                        hs_rdata_reg <= ram_rdata;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + 2'd1;
                    end
                end

                ST_RELEASE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // RAM port mux
    // -----------------------------------------------------------------------
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
        case (state_reg)
            // Gating with reset_n keeps the RAM write-protected while reset
            // is asserted, whatever the CPU is doing.
            ST_IDLE: ram_we = cpu_we & reset_n;
            ST_GRANT: begin
                ram_addr  = hs_addr;
                ram_wdata = hs_wdata;
            end
            ST_ACCESS: begin
                ram_addr  = hs_addr;
                ram_wdata = hs_wdata;
                // Write only in the first ACCESS cycle, before the ack shows.
                ram_we    = we_lat_reg & ~hs_ack_reg;
            end
            default: ;
        endcase
    end

    assign hs_busy   = (state_reg == ST_GRANT) || (state_reg == ST_ACCESS);
    assign cpu_pause = user_pause | (state_reg != ST_IDLE);
    assign hs_ack    = hs_ack_reg;
    assign hs_rdata  = hs_rdata_reg;

`ifdef ARB_PAUSE_DIM_EN
    // -----------------------------------------------------------------------
    // Screen-dim timer. It is driven only by the user pause, never by
    // hiscore pauses.
    // -----------------------------------------------------------------------
    logic [31:0] dim_timer_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dim_timer_reg <= 32'd0;
        end else if (!user_pause) begin
            dim_timer_reg <= 32'd0;
        end else if (dim_timer_reg < DIM_CYCLES) begin
            dim_timer_reg <= dim_timer_reg + 32'd1;
        end
    end

    assign dim = (dim_timer_reg >= DIM_CYCLES);
`endif

endmodule
